// File: rtl/core_ctrl_pkg.sv
// Shared definitions for the convolution-pass sequencer: instruction word layout,
// array geometry, address widths and the sequencer state encoding.
package core_ctrl_pkg;

   localparam int ROW    = 8;
   localparam int COL    = 8;
   localparam int ADDR_W = 11;
   localparam int KIJ_W  = 4;
   localparam int INST_W = 34;

   localparam int ACC_B      = 33;
   localparam int CEN_P_B    = 32;
   localparam int WEN_P_B    = 31;
   localparam int AP_LSB     = 20;
   localparam int CEN_X_B    = 19;
   localparam int WEN_X_B    = 18;
   localparam int AX_LSB     = 7;
   localparam int OFIFO_RD_B = 6;
   localparam int IFIFO_WR_B = 5;
   localparam int IFIFO_RD_B = 4;
   localparam int L0_RD_B    = 3;
   localparam int L0_WR_B    = 2;
   localparam int EXEC_B     = 1;
   localparam int LOAD_B     = 0;

   // Both SRAMs deselected and write-disabled; every strobe low.
   localparam logic [INST_W-1:0] IDLE_INST = (34'd1 << CEN_P_B) | (34'd1 << WEN_P_B) |
                                             (34'd1 << CEN_X_B) | (34'd1 << WEN_X_B);

   typedef enum logic [3:0] {
      S_IDLE   = 4'd0,
      S_W_RD   = 4'd1,
      S_W_TAIL = 4'd2,
      S_KLOAD  = 4'd3,
      S_KGAP   = 4'd4,
      S_X_RD   = 4'd5,
      S_X_TAIL = 4'd6,
      S_EXEC   = 4'd7,
      S_DRAIN  = 4'd8,
      S_NEXT   = 4'd9,
      S_FIN    = 4'd10
   } state_e;

endpackage

// File: rtl/core_seq_sram_rd.sv
// SRAM read-address walker with a one-deep valid pipe producing l0_wr a cycle
// after each read. Shared by the weight and activation load phases.
module core_seq_sram_rd
   import core_ctrl_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              clr_i,
   input  logic              rd_i,
   input  logic [ADDR_W-1:0] base_i,
   input  logic [ADDR_W-1:0] len_i,
   output logic [ADDR_W-1:0] addr_o,
   output logic              last_o,
   output logic              l0_wr_o
);

   logic [ADDR_W-1:0] idx_q;
   logic              vld_q;

   // Read index and read-data-valid pipe.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         idx_q <= {ADDR_W{1'b0}};
         vld_q <= 1'b0;
      end else begin
         vld_q <= rd_i;
         if (clr_i) begin
            idx_q <= {ADDR_W{1'b0}};
         end else if (rd_i) begin
            idx_q <= idx_q + {{(ADDR_W-1){1'b0}}, 1'b1};
         end else begin
            idx_q <= idx_q;
         end
      end
   end

   assign addr_o  = base_i + idx_q;
   assign last_o  = rd_i && (idx_q == (len_i - {{(ADDR_W-1){1'b0}}, 1'b1}));
   assign l0_wr_o = vld_q;

endmodule

// File: rtl/core_seq_ctrl.sv
// Convolution-pass sequencer: per kernel position loads weights, runs the array
// over the activations and drains results into psum SRAM. All outputs registered.
module core_seq_ctrl
   import core_ctrl_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [KIJ_W-1:0]  cfg_num_kij,
   input  logic [ADDR_W-1:0] cfg_x_len,
   input  logic [ADDR_W-1:0] cfg_w_base,
   input  logic [ADDR_W-1:0] cfg_x_base,
   input  logic [ADDR_W-1:0] cfg_p_base,
   input  logic              ofifo_valid,
   output logic [INST_W-1:0] inst,
   output logic              xw_mode,
   output logic              sfp_reset,
   output logic              busy,
   output logic              done
);

   state_e             state_q;
   logic [INST_W-1:0]  inst_q;
   logic               xw_mode_q, sfp_q, busy_q, done_q;
   logic [KIJ_W-1:0]   kij_q, num_kij_q;
   logic [ADDR_W-1:0]  cnt_q, x_len_q, w_base_q, x_base_q, p_base_q;
   logic               rd_en_s, rd_last_s, rd_l0_wr_s;
   logic [ADDR_W-1:0]  rd_base_s, rd_len_s, rd_addr_s;

   // Select the read stream: weights of the current kij or the shared activations.
   always_comb begin
      rd_en_s = (state_q == S_W_RD) || (state_q == S_X_RD);
      if (state_q == S_X_RD) begin
         rd_base_s = x_base_q;
         rd_len_s  = x_len_q;
      end else begin
         rd_base_s = w_base_q + ADDR_W'(kij_q) * ADDR_W'(ROW);
         rd_len_s  = ADDR_W'(ROW);
      end
   end

   core_seq_sram_rd u_rd (
      .clk     (clk),
      .reset   (reset),
      .clr_i   (!rd_en_s),
      .rd_i    (rd_en_s),
      .base_i  (rd_base_s),
      .len_i   (rd_len_s),
      .addr_o  (rd_addr_s),
      .last_o  (rd_last_s),
      .l0_wr_o (rd_l0_wr_s)
   );

   // Sequencer state, counters, latched configuration and registered outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         inst_q    <= IDLE_INST;
         xw_mode_q <= 1'b0;
         sfp_q     <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         kij_q     <= {KIJ_W{1'b0}};
         num_kij_q <= {KIJ_W{1'b0}};
         cnt_q     <= {ADDR_W{1'b0}};
         x_len_q   <= {ADDR_W{1'b0}};
         w_base_q  <= {ADDR_W{1'b0}};
         x_base_q  <= {ADDR_W{1'b0}};
         p_base_q  <= {ADDR_W{1'b0}};
      end else begin
         inst_q          <= IDLE_INST;
         inst_q[L0_WR_B] <= rd_l0_wr_s;
         sfp_q           <= 1'b0;
         done_q          <= 1'b0;
         busy_q          <= (state_q != S_IDLE);
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  num_kij_q <= cfg_num_kij;
                  x_len_q   <= cfg_x_len;
                  w_base_q  <= cfg_w_base;
                  x_base_q  <= cfg_x_base;
                  p_base_q  <= cfg_p_base;
                  kij_q     <= {KIJ_W{1'b0}};
                  cnt_q     <= {ADDR_W{1'b0}};
                  sfp_q     <= 1'b1;
                  busy_q    <= 1'b1;
                  state_q   <= ((cfg_num_kij == {KIJ_W{1'b0}}) || (cfg_x_len == {ADDR_W{1'b0}}))
                               ? S_FIN : S_W_RD;
               end else begin
                  state_q <= S_IDLE;
               end
            end
            S_W_RD, S_X_RD: begin
               xw_mode_q                 <= (state_q == S_W_RD);
               inst_q[CEN_X_B]           <= 1'b0;
               inst_q[AX_LSB +: ADDR_W]  <= rd_addr_s;
               if (rd_last_s) begin
                  state_q <= (state_q == S_W_RD) ? S_W_TAIL : S_X_TAIL;
               end else begin
                  state_q <= state_q;
               end
            end
            S_W_TAIL: begin
               xw_mode_q <= 1'b1;
               cnt_q     <= {ADDR_W{1'b0}};
               state_q   <= S_KLOAD;
            end
            S_KLOAD: begin
               inst_q[L0_RD_B] <= 1'b1;
               inst_q[LOAD_B]  <= 1'b1;
               if (cnt_q == ADDR_W'(ROW - 1)) begin
                  cnt_q   <= {ADDR_W{1'b0}};
                  state_q <= S_KGAP;
               end else begin
                  cnt_q <= cnt_q + 11'd1;
               end
            end
            S_KGAP: begin
               if (cnt_q == ADDR_W'(ROW + COL - 1)) begin
                  cnt_q   <= {ADDR_W{1'b0}};
                  state_q <= S_X_RD;
               end else begin
                  cnt_q <= cnt_q + 11'd1;
               end
            end
            S_X_TAIL: begin
               xw_mode_q <= 1'b0;
               cnt_q     <= {ADDR_W{1'b0}};
               state_q   <= S_EXEC;
            end
            S_EXEC: begin
               inst_q[L0_RD_B] <= 1'b1;
               inst_q[EXEC_B]  <= 1'b1;
               if (cnt_q == x_len_q - 11'd1) begin
                  cnt_q   <= {ADDR_W{1'b0}};
                  state_q <= S_DRAIN;
               end else begin
                  cnt_q <= cnt_q + 11'd1;
               end
            end
            S_DRAIN: begin
               if (ofifo_valid) begin
                  inst_q[OFIFO_RD_B]       <= 1'b1;
                  inst_q[CEN_P_B]          <= 1'b0;
                  inst_q[WEN_P_B]          <= 1'b0;
                  inst_q[AP_LSB +: ADDR_W] <= p_base_q + cnt_q;
                  inst_q[ACC_B]            <= (kij_q != {KIJ_W{1'b0}});
                  if (cnt_q == x_len_q - 11'd1) begin
                     cnt_q   <= {ADDR_W{1'b0}};
                     state_q <= S_NEXT;
                  end else begin
                     cnt_q <= cnt_q + 11'd1;
                  end
               end else begin
                  state_q <= S_DRAIN;
               end
            end
            S_NEXT: begin
               kij_q   <= kij_q + 4'd1;
               state_q <= ((kij_q + 4'd1) == num_kij_q) ? S_FIN : S_W_RD;
            end
            S_FIN: begin
               done_q  <= 1'b1;
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign inst      = inst_q;
   assign xw_mode   = xw_mode_q;
   assign sfp_reset = sfp_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule
